spi_burst_ctrl: RTL

// - Sequences multi-byte SPI bursts on the existing single-byte spi engine; sits between the peripheral register block and spi.
// - CPU queues bytes in a TX FIFO and writes a byte count to go; block drives chip select, start/busy handshake per byte, queues received bytes in an RX FIFO.
// - Removes per-byte CPU polling of spi_busy.

---
 rtl/spi_burst_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_ctrl.sv
// Multi-byte SPI burst sequencer over a single-byte engine: TX/RX byte FIFOs, chip-select framing, start/busy handshake per byte.
// Optional per-byte CS framing (CS_GAP high cycles between bytes) is built when SPI_BURST_CS_GAP_EN is defined.

module spi_burst_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

module spi_burst_ctrl #(
  parameter int         DEPTH   = 8,
  parameter int         TIMEOUT = 255,
  parameter logic [7:0] FILL    = 8'hff,
  parameter int         CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_push,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  input  logic       rx_pop,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  input  logic       go,
  input  logic [3:0] count,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic       cs_n,
  output logic       spi_start,
  output logic [7:0] spi_data_tx,
  input  logic [7:0] spi_data_rx,
  input  logic       spi_busy
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_CS_SETUP, ST_LOAD, ST_START, ST_WAIT_HI,
    ST_WAIT_LO, ST_CAPTURE, ST_CS_GAP, ST_CS_HOLD, ST_FINISH
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_burst_ctrl: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255 || CS_GAP < 1 || CS_GAP > 255) begin : g_bad_timing
    $error("spi_burst_ctrl: TIMEOUT and CS_GAP must be in 1..255");
  end

  state_t     state;
  logic [3:0] remaining;
  logic [7:0] timer;
  logic       tx_empty;
  logic [7:0] tx_head;
  logic       tx_pop;
  logic       rx_full;
  logic       rx_push;

  assign tx_pop  = (state == ST_LOAD);
  assign rx_push = (state == ST_CAPTURE);

  spi_burst_fifo #(.DEPTH(DEPTH), .W(8)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // A capture into a full RX FIFO is dropped inside the FIFO; the FSM only flags it.
  spi_burst_fifo #(.DEPTH(DEPTH), .W(8)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (spi_data_rx),
    .pop       (rx_pop),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

`ifdef SPI_BURST_CS_GAP_EN
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  logic [7:0] gap_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      timer       <= '0;
      cs_n        <= 1'b1;
      spi_start   <= 1'b0;
      spi_data_tx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= '0;
`ifdef SPI_BURST_CS_GAP_EN
      gap_cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // FINISH has already dropped busy, so a new go is honoured there too.
        ST_IDLE, ST_FINISH: begin
          state <= ST_IDLE;
          if (go) begin
            status <= '0;
            if (count != 4'd0) begin
              remaining <= count;
              busy      <= 1'b1;
              cs_n      <= 1'b0;
              state     <= ST_CS_SETUP;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_CS_SETUP: state <= ST_LOAD;
        ST_LOAD: begin
          spi_data_tx <= tx_empty ? FILL : tx_head;
          spi_start   <= 1'b1;
          state       <= ST_START;
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (spi_busy) begin
            spi_start <= 1'b0;
            state     <= ST_WAIT_LO;
          end else if (timer == TO_LAST) begin
            spi_start <= 1'b0;
            status[1] <= 1'b1;
            state     <= ST_CS_HOLD;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!spi_busy) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (rx_full) status[0] <= 1'b1;
          remaining <= remaining - 4'd1;
          if (remaining != 4'd1) begin
`ifdef SPI_BURST_CS_GAP_EN
            cs_n    <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_CS_GAP;
`else
            state   <= ST_LOAD;
`endif
          end else begin
            state <= ST_CS_HOLD;
          end
        end
`ifdef SPI_BURST_CS_GAP_EN
        ST_CS_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            cs_n  <= 1'b0;
            state <= ST_CS_SETUP;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
`endif
        ST_CS_HOLD: begin
          cs_n  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_FINISH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
